// File: rtl/mux_rr_arbiter_if.sv
// Requester and output-channel bundle for mux_rr_arbiter.
// slave is the arbiter side, master is the producer/consumer side.
interface mux_rr_arbiter_if #(
   parameter int NR_REQ   = 4,
   parameter int DATA_LEN = 32,
   parameter int SEL_LEN  = 2
);
   logic [NR_REQ-1:0]          req_valid;
   logic [NR_REQ-1:0]          req_last;
   logic [NR_REQ*DATA_LEN-1:0] req_data;
   logic [NR_REQ-1:0]          req_ready;
   logic                       out_valid;
   logic                       out_last;
   logic [DATA_LEN-1:0]        out_data;
   logic [SEL_LEN-1:0]         out_sel;
   logic                       out_ready;
   logic                       busy;

   modport slave (
      input  req_valid, req_last, req_data, out_ready,
      output req_ready, out_valid, out_last, out_data,
      output out_sel, busy
   );

   modport master (
      output req_valid, req_last, req_data, out_ready,
      input  req_ready, out_valid, out_last, out_data,
      input  out_sel, busy
   );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter: grant held from first beat to last,
// accepted beats pass through a one-entry registered output stage.
module mux_rr_arbiter #(
   parameter int NR_REQ   = 4,
   parameter int DATA_LEN = 32,
   parameter int SEL_LEN  = 2
) (
   input logic             clk,
   input logic             rst_n,
   mux_rr_arbiter_if.slave bus
);
   typedef enum logic {IDLE, LOCK} state_e;

   state_e              state_q, state_d;
   logic [SEL_LEN-1:0]  grant_sel_q, grant_sel_d;
   logic [SEL_LEN-1:0]  ptr_q, ptr_d;
   logic                buf_valid_q, buf_valid_d;
   logic                buf_last_q, buf_last_d;
   logic [DATA_LEN-1:0] buf_data_q, buf_data_d;
   logic [SEL_LEN-1:0]  buf_sel_q, buf_sel_d;

   logic [NR_REQ-1:0]   rot;
   logic [SEL_LEN-1:0]  pick;
   logic                pick_ok;
   int                  pick_sum;
   logic                mux_valid;
   logic                mux_last;
   logic [DATA_LEN-1:0] mux_data;
   logic                slot_free;
   logic                acc;
   logic [NR_REQ-1:0]   ready;

   // rot[k] is the request at ptr+k, so the lowest set k wins
   always_comb begin
      rot      = NR_REQ'({bus.req_valid, bus.req_valid} >> ptr_q);
      pick     = '0;
      pick_sum = 0;
      pick_ok  = |bus.req_valid;
      for (int k = NR_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            pick_sum = int'(ptr_q) + k;
            if (pick_sum >= NR_REQ) begin
               pick_sum = pick_sum - NR_REQ;
            end
            pick = SEL_LEN'(pick_sum);
         end
      end
   end

   always_comb begin
      mux_valid = 1'b0;
      mux_last  = 1'b0;
      mux_data  = '0;
      for (int n = 0; n < NR_REQ; n++) begin
         if (grant_sel_q == SEL_LEN'(n)) begin
            mux_valid = bus.req_valid[n];
            mux_last  = bus.req_last[n];
            mux_data  = bus.req_data[n*DATA_LEN +: DATA_LEN];
         end
      end
   end

   assign slot_free = !buf_valid_q || bus.out_ready;

   always_comb begin
      ready = '0;
      for (int n = 0; n < NR_REQ; n++) begin
         ready[n] = (state_q == LOCK) &&
                    (grant_sel_q == SEL_LEN'(n)) &&
                    slot_free;
      end
   end

   assign acc = (state_q == LOCK) && mux_valid && slot_free;

   always_comb begin
      state_d     = state_q;
      grant_sel_d = grant_sel_q;
      ptr_d       = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_ok) begin
               grant_sel_d = pick;
               state_d     = LOCK;
            end
         end
         LOCK: begin
            if (acc && mux_last) begin
               state_d = IDLE;
               if (grant_sel_q == SEL_LEN'(NR_REQ - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = grant_sel_q + 1'b1;
               end
            end
         end
      endcase
   end

   // a new beat may overwrite one that drains this same cycle
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_last_d  = buf_last_q;
      buf_data_d  = buf_data_q;
      buf_sel_d   = buf_sel_q;
      if (acc) begin
         buf_valid_d = 1'b1;
         buf_last_d  = mux_last;
         buf_data_d  = mux_data;
         buf_sel_d   = grant_sel_q;
      end else if (buf_valid_q && bus.out_ready) begin
         buf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_sel_q <= '0;
         ptr_q       <= '0;
         buf_valid_q <= 1'b0;
         buf_last_q  <= 1'b0;
         buf_data_q  <= '0;
         buf_sel_q   <= '0;
      end else begin
         state_q     <= state_d;
         grant_sel_q <= grant_sel_d;
         ptr_q       <= ptr_d;
         buf_valid_q <= buf_valid_d;
         buf_last_q  <= buf_last_d;
         buf_data_q  <= buf_data_d;
         buf_sel_q   <= buf_sel_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.out_valid = buf_valid_q;
   assign bus.out_last  = buf_last_q;
   assign bus.out_data  = buf_data_q;
   assign bus.out_sel   = buf_sel_q;
   assign bus.busy      = (state_q == LOCK);
endmodule
